// File: rtl/pdp8_pkg.sv
// Shared widths, types and the memory-controller state encoding for the exec memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

    localparam int AW    = `ADDR_WIDTH;
    localparam int DW    = `DATA_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int CNT_W = 16;

    typedef logic [AW-1:0]    addr_t;
    typedef logic [DW-1:0]    data_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } mem_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/exec_mem_responder_if.sv
// Request/response bundle between an execution unit and the memory responder.
// Latency: n/a (wires only).
// Backpressure: none; the requester must watch mem_ready before issuing.
interface exec_mem_responder_if;
    import pdp8_pkg::*;

    logic  exec_rd_req;
    addr_t exec_rd_addr;
    data_t exec_rd_data;
    logic  exec_wr_req;
    addr_t exec_wr_addr;
    data_t exec_wr_data;
    logic  mem_ready;
    logic  rd_valid;
    logic  proto_err;
    cnt_t  rd_count;
    cnt_t  wr_count;

    modport master (
        output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
        input  exec_rd_data, mem_ready, rd_valid, proto_err, rd_count, wr_count
    );

    modport slave (
        input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
        output exec_rd_data, mem_ready, rd_valid, proto_err, rd_count, wr_count
    );

endinterface

// File: rtl/rd_delay_pipe.sv
// Shift pipeline carrying read valid+data from the request edge to the consumer.
// Latency: RD_LATENCY edges; data registered at the request edge is presented after edge N+RD_LATENCY-1.
// Backpressure: none; accepts one entry every cycle. Data stages only load on valid, so the last stage holds.
module rd_delay_pipe
    import pdp8_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int PIPE_DW    = `DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_vld,
    input  logic [PIPE_DW-1:0] in_dat,
    output logic               out_vld,
    output logic [PIPE_DW-1:0] out_dat
);

    logic [RD_LATENCY-1:0]              vld_q, vld_d;
    logic [RD_LATENCY-1:0][PIPE_DW-1:0] dat_q, dat_d;

    // Advance valids every cycle; each data stage only captures when its upstream stage is valid.
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = in_vld;
        dat_d[0] = in_vld ? in_dat : dat_q[0];
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    // Pipeline registers; reset drops anything in flight and zeroes the held output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q[RD_LATENCY-1];
    assign out_dat = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/exec_mem_responder.sv
// 4K x 12 word memory serving pipelined reads and single-cycle writes after a zero-fill sweep.
// Latency: read data/rd_valid after edge N+RD_LATENCY-1; writes land at the request edge.
// Backpressure: none; requests outside RUN are dropped and latch proto_err.
module exec_mem_responder
    import pdp8_pkg::*;
#(
    parameter int RD_LATENCY     = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    exec_mem_responder_if.slave  bus
);

    mem_state_e state_q, state_d;
    addr_t      clr_cnt_q, clr_cnt_d;
    logic       proto_err_q, proto_err_d;
    cnt_t       rd_count_q, rd_count_d;
    cnt_t       wr_count_q, wr_count_d;

    logic       run;
    logic       rd_fire;
    logic       wr_fire;
    logic       mem_we;
    addr_t      mem_waddr;
    data_t      mem_wdata;
    data_t      rd_dat_in;

    // Storage is deliberately unreset; its contents are defined by the CLEAR sweep.
    data_t      mem [DEPTH];

    assign run     = (state_q == RUN);
    assign rd_fire = run && bus.exec_rd_req;
    assign wr_fire = run && bus.exec_wr_req;

    // Next state and the single memory write port: CLEAR sweep owns it, RUN hands it to the requester.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = bus.exec_wr_addr;
        mem_wdata = bus.exec_wr_data;
        case (state_q)
            IDLE: begin
                state_d = CLEAR_ON_RESET ? CLEAR : RUN;
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + addr_t'(1);
                if (clr_cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = wr_fire;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky protocol error and saturating service counters.
    always_comb begin
        proto_err_d = proto_err_q | (!run && (bus.exec_rd_req || bus.exec_wr_req));
        rd_count_d  = rd_fire ? sat_inc(rd_count_q) : rd_count_q;
        wr_count_d  = wr_fire ? sat_inc(wr_count_q) : wr_count_q;
    end

    // Read data is captured at the request edge; a same-edge write to the same word forwards the new value.
    always_comb begin
        rd_dat_in = mem[bus.exec_rd_addr];
        if (wr_fire && (bus.exec_wr_addr == bus.exec_rd_addr)) begin
            rd_dat_in = bus.exec_wr_data;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            proto_err_q <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            proto_err_q <= proto_err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Single write port into the RAM array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    rd_delay_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .PIPE_DW    (DW)
    ) u_rd_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (rd_fire),
        .in_dat  (rd_dat_in),
        .out_vld (bus.rd_valid),
        .out_dat (bus.exec_rd_data)
    );

    assign bus.mem_ready = run;
    assign bus.proto_err = proto_err_q;
    assign bus.rd_count  = rd_count_q;
    assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_exec_mem_responder.sv
// Bench for exec_mem_responder: two instances (read latency 1 and 3) driven with identical traffic.
// Expected results come from a word-array model plus per-instance queues of due read returns.
// Each step drives at the falling edge, models at the rising edge, and checks at the next falling edge.
module tb_exec_mem_responder;
    import pdp8_pkg::*;

    logic  clk     = 1'b0;
    logic  reset_n = 1'b1;
    logic  rd_req  = 1'b0;
    addr_t rd_addr = '0;
    logic  wr_req  = 1'b0;
    addr_t wr_addr = '0;
    data_t wr_data = '0;

    always #5 clk = ~clk;

    exec_mem_responder_if bus0();
    exec_mem_responder_if bus1();

    assign bus0.exec_rd_req  = rd_req;
    assign bus0.exec_rd_addr = rd_addr;
    assign bus0.exec_wr_req  = wr_req;
    assign bus0.exec_wr_addr = wr_addr;
    assign bus0.exec_wr_data = wr_data;
    assign bus1.exec_rd_req  = rd_req;
    assign bus1.exec_rd_addr = rd_addr;
    assign bus1.exec_wr_req  = wr_req;
    assign bus1.exec_wr_addr = wr_addr;
    assign bus1.exec_wr_data = wr_data;

    exec_mem_responder #(.RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    exec_mem_responder #(.RD_LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut_l3 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    // Reference model state.
    typedef struct { int due; data_t dat; } pend_t;
    data_t mdl [DEPTH];
    pend_t q1 [$];
    pend_t q3 [$];
    data_t last1, last3;
    cnt_t  exp_rc, exp_wc;
    logic  exp_perr;
    int    cyc;        // rising edges since reset release
    int    rdy_cyc;    // edge after which mem_ready was first seen high
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, obs, exp, $time, cyc);
        end
    endtask

    task automatic chk_bus(input string p, input logic v, input data_t d, input logic rdy,
                           input logic pe, input cnt_t rc, input cnt_t wc,
                           input logic ev, input data_t ed);
        chk({p, ".rd_valid"},     32'(v),   32'(ev));
        chk({p, ".exec_rd_data"}, 32'(d),   32'(ed));
        chk({p, ".mem_ready"},    32'(rdy), 32'(cyc >= 4097));
        chk({p, ".proto_err"},    32'(pe),  32'(exp_perr));
        chk({p, ".rd_count"},     32'(rc),  32'(exp_rc));
        chk({p, ".wr_count"},     32'(wc),  32'(exp_wc));
    endtask

    task automatic model_reset();
        q1.delete();
        q3.delete();
        last1    = '0;
        last3    = '0;
        exp_rc   = '0;
        exp_wc   = '0;
        exp_perr = 1'b0;
        cyc      = 0;
        rdy_cyc  = 0;
        // After a full sweep every word reads zero; nothing is reachable before then.
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    // Called at a falling edge: assert reset, check the async reset state, release at a later falling edge.
    task automatic do_reset(input int hold);
        reset_n = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        model_reset();
        #1;
        chk_bus("rst.L1", bus0.rd_valid, bus0.exec_rd_data, bus0.mem_ready, bus0.proto_err,
                bus0.rd_count, bus0.wr_count, 1'b0, '0);
        chk_bus("rst.L3", bus1.rd_valid, bus1.exec_rd_data, bus1.mem_ready, bus1.proto_err,
                bus1.rd_count, bus1.wr_count, 1'b0, '0);
        repeat (hold) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock of stimulus, model update and output check.
    task automatic step(input logic rd, input addr_t ra, input logic wr, input addr_t wa, input data_t wd);
        logic  srv;
        logic  ev1, ev3;
        data_t ed1, ed3;
        data_t v;
        rd_req  = rd;
        rd_addr = ra;
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        @(posedge clk);
        cyc++;
        // One IDLE edge plus 4096 CLEAR edges precede the first serviced request.
        srv = (cyc >= 4098);
        if ((rd || wr) && !srv) exp_perr = 1'b1;
        if (srv && rd) begin
            v = (wr && (wa == ra)) ? wd : mdl[ra];
            q1.push_back('{cyc, v});
            q3.push_back('{cyc + 2, v});
            if (exp_rc != 16'hFFFF) exp_rc++;
        end
        if (srv && wr) begin
            mdl[wa] = wd;
            if (exp_wc != 16'hFFFF) exp_wc++;
        end
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        if (bus0.mem_ready === 1'b1 && rdy_cyc == 0) rdy_cyc = cyc;
        ev1 = 1'b0;
        ed1 = last1;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            ev1 = 1'b1;
            ed1 = q1[0].dat;
            last1 = ed1;
            void'(q1.pop_front());
        end
        ev3 = 1'b0;
        ed3 = last3;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            ev3 = 1'b1;
            ed3 = q3[0].dat;
            last3 = ed3;
            void'(q3.pop_front());
        end
        chk_bus("L1", bus0.rd_valid, bus0.exec_rd_data, bus0.mem_ready, bus0.proto_err,
                bus0.rd_count, bus0.wr_count, ev1, ed1);
        chk_bus("L3", bus1.rd_valid, bus1.exec_rd_data, bus1.mem_ready, bus1.proto_err,
                bus1.rd_count, bus1.wr_count, ev3, ed3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
    endtask

    // Bounded wait for RUN; an illegal write is injected once the sweep has passed its target word.
    task automatic wait_ready(input logic inject);
        for (int i = 0; i < 4300 && bus0.mem_ready !== 1'b1; i++) begin
            if (inject && i == 100) step(1'b1, 12'o0005, 1'b1, 12'o0005, 12'o7777);
            else                    step(1'b0, '0, 1'b0, '0, '0);
        end
        chk("ready_at", 32'(rdy_cyc), 32'd4097);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(3);

        // Abort a sweep halfway, with an illegal read setting proto_err first.
        idle(4);
        step(1'b1, 12'o0100, 1'b0, '0, '0);
        idle(1995);
        do_reset(2);

        // Full sweep with an ignored write during CLEAR.
        wait_ready(1'b1);

        // Top word and the word targeted during CLEAR both read zero.
        step(1'b1, 12'o7777, 1'b0, '0, '0);
        step(1'b1, 12'o0005, 1'b0, '0, '0);
        idle(4);

        // Simple write then read.
        step(1'b0, '0, 1'b1, 12'o0200, 12'o1234);
        step(1'b1, 12'o0200, 1'b0, '0, '0);
        idle(4);

        // Same-edge read/write forwarding, then a write chasing an in-flight read.
        step(1'b1, 12'o0010, 1'b1, 12'o0010, 12'o5555);
        idle(4);
        step(1'b1, 12'o0010, 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 12'o0010, 12'o0001);
        idle(4);

        // Back-to-back reads of a preloaded block, plus a simultaneous different-address pair.
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, addr_t'(i), data_t'(12'o0100 + i));
        for (int i = 0; i < 4; i++) step(1'b1, addr_t'(i), 1'b0, '0, '0);
        step(1'b1, 12'o0002, 1'b1, 12'o0003, 12'o4321);
        step(1'b1, 12'o0003, 1'b0, '0, '0);
        idle(4);

        // Random traffic over a small address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 15)),
                 data_t'($urandom));
        end
        idle(4);

        // Reset with a read still in the latency-3 pipeline; it must never surface.
        step(1'b1, 12'o0200, 1'b0, '0, '0);
        do_reset(2);
        idle(6);
        wait_ready(1'b0);
        step(1'b1, 12'o0200, 1'b0, '0, '0);
        idle(4);

        chk("drain", 32'(q1.size() + q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
